i2c_cmd_arbiter: RTL and testbench

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

---
 rtl/i2cmb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/i2c_cmd_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2cmb_pkg.sv
// rtl/i2cmb_pkg.sv - shared I2C command/op types for the command arbiter
package i2cmb_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_START    = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4,
    CMD_STOP     = 3'd5
  } i2c_cmd_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } i2c_op_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot selector starting the search at ptr_i
module rr_arbiter
  import i2cmb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int k;
    k       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sequencing one I2C transaction per grant
module i2c_cmd_arbiter
  import i2cmb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0]                   req_rw_i,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   done_o,
  output logic                                 err_o,
  output logic [I2C_DATA_WIDTH-1:0]            rdata_o,
  output logic                                 cmd_valid_o,
  input  logic                                 cmd_ready_i,
  output logic [2:0]                           cmd_o,
  output logic [I2C_DATA_WIDTH-1:0]            cmd_data_o,
  input  logic                                 rsp_valid_i,
  input  logic                                 rsp_nak_i,
  input  logic [I2C_DATA_WIDTH-1:0]            rsp_data_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int AW    = I2C_ADDR_WIDTH;
  localparam int DW    = I2C_DATA_WIDTH;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic PH_ISSUE = 1'b0;
  localparam logic PH_WAIT  = 1'b1;

  logic [2:0]         state_q, state_d;
  logic               phase_q, phase_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  i2c_op_t            rw_q, rw_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          ptr_d   = IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
          rw_d    = i2c_op_t'(req_rw_i[arb_idx]);
          addr_d  = req_addr_i[int'(arb_idx)*AW +: AW];
          wdata_d = req_wdata_i[int'(arb_idx)*DW +: DW];
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_START;
          phase_d = PH_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        // Responses only count while a command is outstanding.
        if (phase_q == PH_ISSUE) begin
          if (cmd_ready_i) phase_d = PH_WAIT;
        end else if (rsp_valid_i) begin
          phase_d = PH_ISSUE;
          case (state_q)
            ST_START: state_d = ST_ADDR;
            ST_ADDR: begin
              if (rsp_nak_i) begin
                err_d   = 1'b1;
                state_d = ST_STOP;
              end else begin
                state_d = ST_DATA;
              end
            end
            ST_DATA: begin
              if (rw_q == OP_READ) rdata_d = rsp_data_i;
              else if (rsp_nak_i) err_d = 1'b1;
              state_d = ST_STOP;
            end
            ST_STOP: state_d = ST_DONE;
            default: begin
              state_d = ST_IDLE;
              gnt_d   = '0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      rw_q    <= OP_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_o       = CMD_NOP;
    cmd_data_o  = '0;
    if (phase_q == PH_ISSUE) begin
      case (state_q)
        ST_START: begin
          cmd_valid_o = 1'b1;
          cmd_o       = CMD_START;
        end
        ST_ADDR: begin
          cmd_valid_o = 1'b1;
          cmd_o       = CMD_WRITE;
          cmd_data_o  = DW'({addr_q, rw_q});
        end
        ST_DATA: begin
          cmd_valid_o = 1'b1;
          if (rw_q == OP_READ) begin
            cmd_o = CMD_READ_NAK;
          end else begin
            cmd_o      = CMD_WRITE;
            cmd_data_o = wdata_q;
          end
        end
        ST_STOP: begin
          cmd_valid_o = 1'b1;
          cmd_o       = CMD_STOP;
        end
        default: cmd_valid_o = 1'b0;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = (state_q == ST_DONE) ? gnt_q : '0;
  assign err_o   = (state_q == ST_DONE) && err_q;
  assign rdata_o = (state_q == ST_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - directed vector bench with a small I2C engine responder
module tb_i2c_cmd_arbiter;
  import i2cmb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [3:0]  req_rw_i = '0;
  logic [27:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  gnt_o, done_o;
  logic        err_o, cmd_valid_o;
  logic [7:0]  rdata_o, cmd_data_o;
  logic [2:0]  cmd_o;
  logic        cmd_ready_i = 1'b1;
  logic        rsp_valid_i = 1'b0;
  logic        rsp_nak_i = 1'b0;
  logic [7:0]  rsp_data_i = '0;

  int checks = 0;
  int failures = 0;

  i2c_cmd_arbiter #(
    .NUM_REQ(4), .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .req_rw_i(req_rw_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .cmd_o(cmd_o), .cmd_data_o(cmd_data_o),
    .rsp_valid_i(rsp_valid_i), .rsp_nak_i(rsp_nak_i), .rsp_data_i(rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: logs accepted commands, answers one cycle later.
  logic [2:0] log_cmd[32];
  logic [7:0] log_dat[32];
  int         log_n = 0;
  logic       eng_anak = 1'b0, eng_dnak = 1'b0;
  logic [7:0] eng_data = '0;
  int         stall_left = 0;
  logic [7:0] stall_byte = '0;
  int         hold_idx = 99;
  logic       pend = 1'b0, pend_nak = 1'b0;
  int         pend_idx = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      rsp_valid_i = 1'b0;
      rsp_nak_i   = 1'b0;
      cmd_ready_i = 1'b1;
      if (!rst_n_i) begin
        pend = 1'b0;
      end else begin
        if (pend && pend_idx != hold_idx) begin
          rsp_valid_i = 1'b1;
          rsp_nak_i   = pend_nak;
          rsp_data_i  = eng_data;
          pend        = 1'b0;
        end
        if (cmd_valid_o && log_n == 1 && stall_left > 0) begin
          cmd_ready_i = 1'b0;
          stall_left--;
          rsp_valid_i = 1'b1;
          rsp_nak_i   = 1'b1;
          chk("stall_valid", cmd_valid_o, 1);
          chk("stall_cmd", cmd_o, CMD_WRITE);
          chk("stall_data", cmd_data_o, stall_byte);
        end
        if (cmd_valid_o && cmd_ready_i && log_n < 32) begin
          log_cmd[log_n] = cmd_o;
          log_dat[log_n] = cmd_data_o;
          pend     = 1'b1;
          pend_idx = log_n;
          pend_nak = (log_n == 1 && eng_anak) || (log_n == 2 && eng_dnak);
          log_n++;
        end
      end
    end
  end

  task automatic wait_done(input logic drop, output logic [3:0] d);
    int n;
    d = '0;
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      if (drop && gnt_o != 4'b0) req_i = 4'b0;
      if (done_o != 4'b0) begin
        d = done_o;
        break;
      end
      n++;
    end
    if (d == 4'b0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done_o in 300 cycles, required a done pulse");
    end
  endtask

  typedef struct {
    int         k;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       anak, dnak;
    logic [7:0] edata;
    int         stall;
    logic       drop;
    logic [3:0] e_done;
    logic       e_err;
    logic [7:0] e_rdata;
    int         e_n;
    logic [11:0] e_c;
    logic [31:0] e_d;
  } vec_t;

  function automatic vec_t mk(int k, logic rw, logic [6:0] a, logic [7:0] wd, logic an,
                              logic dn, logic [7:0] ed, int st, logic dr, logic [3:0] edn,
                              logic eer, logic [7:0] erd, int en, logic [11:0] ec, logic [31:0] edd);
    vec_t v;
    v.k = k; v.rw = rw; v.addr = a; v.wdata = wd; v.anak = an; v.dnak = dn;
    v.edata = ed; v.stall = st; v.drop = dr; v.e_done = edn; v.e_err = eer;
    v.e_rdata = erd; v.e_n = en; v.e_c = ec; v.e_d = edd;
    return v;
  endfunction

  initial begin
    vec_t       tv[8];
    logic [3:0] rr_exp[5];
    logic [3:0] d;
    int         n;

    tv[0] = mk(0, 0, 7'h22, 8'hA5, 0, 0, 8'hEE, 0, 0, 4'b0001, 0, 8'h00, 4,
               {CMD_START, CMD_WRITE, CMD_WRITE, CMD_STOP}, 32'h0044_A500);
    tv[1] = mk(2, 1, 7'h22, 8'h00, 0, 0, 8'h5C, 0, 0, 4'b0100, 0, 8'h5C, 4,
               {CMD_START, CMD_WRITE, CMD_READ_NAK, CMD_STOP}, 32'h0045_0000);
    tv[2] = mk(1, 0, 7'h50, 8'h11, 1, 0, 8'h00, 0, 0, 4'b0010, 1, 8'h00, 3,
               {CMD_START, CMD_WRITE, CMD_STOP, CMD_NOP}, 32'h00A0_0000);
    tv[3] = mk(3, 0, 7'h7F, 8'h3C, 0, 1, 8'h12, 0, 0, 4'b1000, 1, 8'h00, 4,
               {CMD_START, CMD_WRITE, CMD_WRITE, CMD_STOP}, 32'h00FE_3C00);
    tv[4] = mk(1, 1, 7'h10, 8'h00, 1, 0, 8'h99, 0, 0, 4'b0010, 1, 8'h00, 3,
               {CMD_START, CMD_WRITE, CMD_STOP, CMD_NOP}, 32'h0021_0000);
    tv[5] = mk(3, 1, 7'h01, 8'h00, 0, 1, 8'hFF, 0, 0, 4'b1000, 0, 8'hFF, 4,
               {CMD_START, CMD_WRITE, CMD_READ_NAK, CMD_STOP}, 32'h0003_0000);
    tv[6] = mk(0, 0, 7'h22, 8'hA5, 0, 0, 8'h00, 0, 1, 4'b0001, 0, 8'h00, 4,
               {CMD_START, CMD_WRITE, CMD_WRITE, CMD_STOP}, 32'h0044_A500);
    tv[7] = mk(2, 0, 7'h33, 8'h77, 0, 0, 8'h00, 5, 0, 4'b0100, 0, 8'h00, 4,
               {CMD_START, CMD_WRITE, CMD_WRITE, CMD_STOP}, 32'h0066_7700);
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_cmd", cmd_o, CMD_NOP);
    chk("rst_cmd_data", cmd_data_o, 0);
    rst_n_i = 1'b1;

    // Round-robin with all requesters held high
    @(negedge clk_i);
    log_n = 0;
    req_rw_i = 4'b0;
    req_addr_i = {7'h13, 7'h12, 7'h11, 7'h10};
    req_wdata_i = 32'h4433_2211;
    req_i = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_done(1'b0, d);
      if (g == 4) req_i = 4'b0;
      chk($sformatf("rr_grant%0d", g), d, rr_exp[g]);
    end
    @(negedge clk_i);

    // Single-requester vectors
    for (int v = 0; v < 8; v++) begin
      @(negedge clk_i);
      log_n = 0;
      eng_anak = tv[v].anak;
      eng_dnak = tv[v].dnak;
      eng_data = tv[v].edata;
      stall_left = tv[v].stall;
      stall_byte = tv[v].e_d[23:16];
      req_rw_i[tv[v].k] = tv[v].rw;
      req_addr_i[tv[v].k*7 +: 7] = tv[v].addr;
      req_wdata_i[tv[v].k*8 +: 8] = tv[v].wdata;
      req_i = 4'b0001 << tv[v].k;
      wait_done(tv[v].drop, d);
      req_i = 4'b0;
      chk($sformatf("v%0d_done", v), d, tv[v].e_done);
      chk($sformatf("v%0d_gnt", v), gnt_o, tv[v].e_done);
      chk($sformatf("v%0d_err", v), err_o, tv[v].e_err);
      chk($sformatf("v%0d_rdata", v), rdata_o, tv[v].e_rdata);
      chk($sformatf("v%0d_ncmd", v), log_n, tv[v].e_n);
      for (int i = 0; i < tv[v].e_n && i < log_n; i++) begin
        chk($sformatf("v%0d_cmd%0d", v, i), log_cmd[i], tv[v].e_c[(3-i)*3 +: 3]);
        if (tv[v].e_c[(3-i)*3 +: 3] == CMD_WRITE)
          chk($sformatf("v%0d_data%0d", v, i), log_dat[i], tv[v].e_d[(3-i)*8 +: 8]);
      end
      @(negedge clk_i);
      chk($sformatf("v%0d_gnt_release", v), gnt_o, 0);
      chk($sformatf("v%0d_done_pulse", v), done_o, 0);
    end

    // Reset during DATA.WAIT of a req2 read
    @(negedge clk_i);
    log_n = 0;
    eng_anak = 1'b0;
    eng_dnak = 1'b0;
    eng_data = 8'h5C;
    hold_idx = 2;
    req_rw_i = 4'b0100;
    req_addr_i[14 +: 7] = 7'h22;
    req_i = 4'b0100;
    n = 0;
    while (log_n < 3 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_wait_reached", (log_n >= 3), 1);
    @(negedge clk_i);
    chk("rst_pre_gnt", gnt_o, 4'b0100);
    chk("rst_pre_cmd_valid", cmd_valid_o, 0);
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_gnt", gnt_o, 0);
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_err", err_o, 0);
    chk("rst_mid_rdata", rdata_o, 0);
    chk("rst_mid_cmd_valid", cmd_valid_o, 0);
    chk("rst_mid_cmd", cmd_o, CMD_NOP);
    chk("rst_mid_cmd_data", cmd_data_o, 0);
    req_rw_i = 4'b0;
    req_i = 4'b1001;
    hold_idx = 99;
    repeat (2) @(negedge clk_i);
    log_n = 0;
    rst_n_i = 1'b1;
    n = 0;
    while (gnt_o == 4'b0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_first_grant", gnt_o, 4'b0001);
    wait_done(1'b0, d);
    req_i = 4'b0;
    chk("rst_first_done", d, 4'b0001);
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
